// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter
//   Shares a single-outstanding memory port between the instruction-fetch and
//   data load/store interfaces of the core. Requests are levels held until
//   their done pulse. Data wins arbitration unless a pending fetch has lost
//   STARVE_LIMIT cycles in a row. A BUSY access that sees no mem_ready for
//   TIMEOUT cycles is dropped with a bus_error pulse and re-arbitrated.
//
// Ports
//   CLK, reset (async, active low)
//   instruction_memory_interface_* : fetch request/address, fetched word
//   instruction_done / _stall       : completion pulse, combinational stall
//   data_memory_interface_*         : load/store request, direction, address,
//                                     byte mask, store data, load word
//   data_done / data_stall          : completion pulse, combinational stall
//   mem_request/write/address/frame_mask/wdata : registered memory access
//   mem_rdata / mem_ready           : memory response
//   bus_error                       : one-cycle pulse on access timeout
module memory_port_arbiter #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned STARVE_LIMIT  = 4,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     instruction_memory_interface_enable,
  input  logic [ADDRESS_WIDTH-1:0] instruction_memory_interface_address,
  output logic [31:0]              instruction_memory_interface_data,
  output logic                     instruction_done,
  output logic                     instruction_stall,
  input  logic                     data_memory_interface_enable,
  input  logic                     data_memory_interface_state,
  input  logic [ADDRESS_WIDTH-1:0] data_memory_interface_address,
  input  logic [3:0]               data_memory_interface_frame_mask,
  input  logic [31:0]              data_memory_interface_wdata,
  output logic [31:0]              data_memory_interface_rdata,
  output logic                     data_done,
  output logic                     data_stall,
  output logic                     mem_request,
  output logic                     mem_write,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [3:0]               mem_frame_mask,
  output logic [31:0]              mem_wdata,
  input  logic [31:0]              mem_rdata,
  input  logic                     mem_ready,
  output logic                     bus_error
);

  typedef enum logic [1:0] {IDLE, INST_BUSY, DATA_BUSY} state_t;

  localparam logic [7:0] STARVE_MAX   = 8'(STARVE_LIMIT);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] starve_cnt;
  logic [7:0] timeout_cnt;
  logic       settle;     // marks the mandatory IDLE cycle after an access ends
  logic       abandoned;  // owner dropped its enable during the access

  logic inst_en, data_en;
  logic can_grant, inst_wins, grant_inst, grant_data, owner_en, starve_hit;

  always_comb begin
    inst_en    = instruction_memory_interface_enable;
    data_en    = data_memory_interface_enable;
    can_grant  = (state == IDLE) && !settle;
    inst_wins  = (starve_cnt >= STARVE_MAX);
    grant_data = can_grant && data_en && !(inst_en && inst_wins);
    grant_inst = can_grant && inst_en && !(data_en && !inst_wins);
    owner_en   = (state == INST_BUSY) ? inst_en : data_en;
    starve_hit = inst_en && ((state == DATA_BUSY) || grant_data);
  end

  always_comb begin
    instruction_stall = inst_en & ~instruction_done;
    data_stall        = data_en & ~data_done;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state                             <= IDLE;
      starve_cnt                        <= '0;
      timeout_cnt                       <= '0;
      settle                            <= 1'b0;
      abandoned                         <= 1'b0;
      instruction_memory_interface_data <= '0;
      instruction_done                  <= 1'b0;
      data_memory_interface_rdata       <= '0;
      data_done                         <= 1'b0;
      mem_request                       <= 1'b0;
      mem_write                         <= 1'b0;
      mem_address                       <= '0;
      mem_frame_mask                    <= '0;
      mem_wdata                         <= '0;
      bus_error                         <= 1'b0;
    end else begin
      instruction_done <= 1'b0;
      data_done        <= 1'b0;
      bus_error        <= 1'b0;
      settle           <= 1'b0;

      if (grant_inst)
        starve_cnt <= '0;
      else if (starve_hit && (starve_cnt < STARVE_MAX))
        starve_cnt <= starve_cnt + 8'd1;

      case (state)
        IDLE: begin
          if (grant_inst) begin
            state          <= INST_BUSY;
            mem_request    <= 1'b1;
            mem_write      <= 1'b0;
            mem_address    <= instruction_memory_interface_address;
            mem_frame_mask <= 4'b1111;
            mem_wdata      <= '0;
            timeout_cnt    <= '0;
            abandoned      <= 1'b0;
          end else if (grant_data) begin
            state          <= DATA_BUSY;
            mem_request    <= 1'b1;
            mem_write      <= data_memory_interface_state;
            mem_address    <= data_memory_interface_address;
            mem_frame_mask <= data_memory_interface_frame_mask;
            mem_wdata      <= data_memory_interface_wdata;
            timeout_cnt    <= '0;
            abandoned      <= 1'b0;
          end
        end
        INST_BUSY, DATA_BUSY: begin
          if (mem_ready) begin
            state       <= IDLE;
            mem_request <= 1'b0;
            settle      <= 1'b1;
            // A requester that let go mid-access gets neither data nor done.
            if (owner_en && !abandoned) begin
              if (state == INST_BUSY) begin
                instruction_memory_interface_data <= mem_rdata;
                instruction_done                  <= 1'b1;
              end else begin
                if (!mem_write)
                  data_memory_interface_rdata <= mem_rdata;
                data_done <= 1'b1;
              end
            end
          end else if (timeout_cnt == TIMEOUT_LAST) begin
            state       <= IDLE;
            mem_request <= 1'b0;
            settle      <= 1'b1;
            bus_error   <= 1'b1;
          end else begin
            timeout_cnt <= timeout_cnt + 8'd1;
            if (!owner_en)
              abandoned <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/memory_port_arbiter.md
Name: memory_port_arbiter

Overview:
Shares one unified memory port between the phoeniX instruction-fetch interface and the data load/store interface. Each core-side request is a level held until completion. The arbiter serializes requests onto a single-outstanding memory port that uses a request/ready handshake, and returns read data with a one-cycle done pulse. It sits between the core and the unified memory/bus, and adds starvation protection and a bus timeout.

Parameters:
ADDRESS_WIDTH, 32, width of core and memory addresses
STARVE_LIMIT, 4, consecutive lost arbitration cycles after which a pending instruction fetch wins over data
TIMEOUT, 255, maximum cycles mem_request waits for mem_ready before aborting (8-bit counter)

Ports:
CLK  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
instruction_memory_interface_enable  input  1  fetch request, held until instruction_done
instruction_memory_interface_address  input  ADDRESS_WIDTH  fetch byte address
instruction_memory_interface_data  output  32  registered fetched word
instruction_done  output  1  one-cycle pulse: fetch complete, data valid
instruction_stall  output  1  enable high and not done this cycle
data_memory_interface_enable  input  1  load/store request, held until data_done
data_memory_interface_state  input  1  0 = READ, 1 = WRITE
data_memory_interface_address  input  ADDRESS_WIDTH  load/store byte address
data_memory_interface_frame_mask  input  4  byte enables, bit3 = byte0 ... bit0 = byte3
data_memory_interface_wdata  input  32  store data
data_memory_interface_rdata  output  32  registered load word
data_done  output  1  one-cycle pulse: load/store complete
data_stall  output  1  enable high and not done this cycle
mem_request  output  1  memory access valid
mem_write  output  1  1 = write
mem_address  output  ADDRESS_WIDTH  registered access address
mem_frame_mask  output  4  byte enables (4'b1111 for fetches)
mem_wdata  output  32  write data
mem_rdata  input  32  read data, valid when mem_ready is high
mem_ready  input  1  access complete
bus_error  output  1  one-cycle pulse on timeout

Behaviour:
- Reset (reset low, asynchronous): state IDLE. All outputs are 0, including the data registers. The starvation and timeout counters clear. mem_request drops immediately even mid-access, and no done pulse is issued.
- States are IDLE, INST_BUSY and DATA_BUSY.
- IDLE: if any enable is high, grant and latch address/write/mask/wdata into the mem_* registers, then go to the matching BUSY state.
  - Grant rule: data wins, unless the starvation count is ≥ STARVE_LIMIT, in which case instruction wins.
- A fetch drives mem_write = 0 and mem_frame_mask = 4'b1111.
- BUSY states: mem_request = 1, and mem_* stays stable until mem_ready is sampled high.
- On mem_ready in INST_BUSY:
  - instruction_memory_interface_data <= mem_rdata.
  - instruction_done pulses for one cycle (the cycle after mem_ready).
  - Go to IDLE.
- On mem_ready in DATA_BUSY:
  - For a read, data_memory_interface_rdata <= mem_rdata. For a write, rdata holds its value.
  - data_done pulses for one cycle.
  - Go to IDLE.
- Minimum latency is 3 cycles from enable to the done pulse: grant, then BUSY with mem_ready high, then done.
- The IDLE cycle after completion is always taken, so back-to-back accesses are 3 cycles apart.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on every cycle the instruction enable is high while DATA_BUSY or a data grant occurs.
  - Clears when an instruction is granted.
- Timeout counter:
  - Counts BUSY cycles with mem_ready low and clears on each grant.
  - When it reaches TIMEOUT: bus_error pulses, the granted requester gets no done pulse, mem_request drops, and the state goes to IDLE.
  - The requester stays stalled and is re-arbitrated.
- Requester enable dropping mid-access: the memory access still completes, the done pulse is suppressed, and the read data register is not updated.
- Stall outputs are combinational: stall = enable & ~done.
- Both enables rising in the same IDLE cycle: data is granted first, the fetch next.

Test Plan:
- Fetch only, address 0x100, mem_ready high on the first request cycle, mem_rdata = 0x00500093 → mem_request high for 1 cycle with mem_address = 0x100 and mask 4'b1111; instruction_done pulses at cycle 3 with instruction data 0x00500093.
- Store to 0x2004, mask 4'b0011, wdata 0xDEADBEEF, mem_ready after 2 wait cycles → mem_write = 1 with fields stable for 3 cycles; data_done pulses once; rdata unchanged.
- Simultaneous fetch and load → the load is granted first and the fetch is issued in the next IDLE cycle; each gets exactly one done pulse with its correct word.
- Data enable held continuously (8 loads) with fetch pending, STARVE_LIMIT = 4 → the fetch is granted no later than the 2nd data completion; the counter returns to 0.
- mem_ready never asserted, TIMEOUT = 255 → bus_error pulses 255 cycles after the grant, mem_request drops, no done pulse, and the request is re-arbitrated.
- Reset pulled low during DATA_BUSY → mem_request is 0 immediately; after release the state is IDLE with no spurious done pulse.
